// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller.
//  - FSM state encoding (IDLE / REQ / SERVICE)
//  - bus field positions for the vector read and the mask command write
//  - mk_vec(): builds the registered read-back vector for a source ID
package irq_pkg;

  localparam int IRQ_ID_W      = 4;
  localparam int VEC_VALID_BIT = 15;
  localparam int CMD_MASK_BIT  = 15;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  // The valid bit marks a real vector; an all-zero read means "nothing to service".
  function automatic logic [15:0] mk_vec(input logic [IRQ_ID_W-1:0] id);
    logic [15:0] v;
    v                 = '0;
    v[VEC_VALID_BIT]  = 1'b1;
    v[IRQ_ID_W-1:0]   = id;
    return v;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set index wins.
// Ports:
//  req  in  NUM_IRQ   request vector (already masked)
//  any  out 1         at least one request set
//  id   out IRQ_ID_W  index of the lowest set request (0 when none)
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0]  req,
  output logic                any,
  output logic [IRQ_ID_W-1:0] id
);

  // Scan from the top so the last hit, i.e. the lowest index, is what remains.
  always_comb begin
    any = |req;
    id  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) id = IRQ_ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: latches rising edges of peripheral request lines,
// selects one by fixed priority (index 0 highest), raises a single CPU
// interrupt, returns the source ID on a bus read and, on an acknowledge
// write, pulses that source's ack_out line for one cycle.
// Optional build macro IRQ_MASK_EN: adds a writable enable mask (a write with
// in_bus[15]=1 loads the mask); without it every source is always enabled.
// Ports:
//  clk        in   1        system clock
//  rst        in   1        synchronous active-high reset
//  read       in   1        bus read strobe
//  write      in   1        bus write strobe
//  in_bus     in   16       bus write data
//  irq_in     in   NUM_IRQ  level requests, held until acked
//  out_bus    out  16       registered read data
//  interrupt  out  1        registered interrupt to the CPU
//  ack_out    out  NUM_IRQ  one-cycle acknowledge pulse per source
module irq_controller
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read,
  input  logic               write,
  input  logic [15:0]        in_bus,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [15:0]        out_bus,
  output logic               interrupt,
  output logic [NUM_IRQ-1:0] ack_out
);

  logic [NUM_IRQ-1:0]  irq_d, pending, mask, set_v, clr_v;
  logic [1:0]          state;
  logic [IRQ_ID_W-1:0] cur_id, elig_id;
  logic                elig_any;
  logic                wr_ok, ack_cmd, do_ack;
  logic                unused_bus;

  // A read in the same cycle as a write takes precedence; the write is dropped.
  assign wr_ok   = write & ~read;
  assign ack_cmd = wr_ok & ~in_bus[CMD_MASK_BIT];
  assign do_ack  = (state == ST_SERVICE) & ack_cmd;

  assign set_v = irq_in & ~irq_d;
  assign clr_v = do_ack ? (NUM_IRQ'(1) << cur_id) : '0;

  assign unused_bus = ^in_bus;

`ifdef IRQ_MASK_EN
  // Mask only gates eligibility; masked edges still land in pending.
  always_ff @(posedge clk) begin
    if (rst)                              mask <= '1;
    else if (wr_ok & in_bus[CMD_MASK_BIT]) mask <= in_bus[NUM_IRQ-1:0];
  end
`else
  assign mask = '1;
`endif

  irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_enc (
    .req (pending & mask),
    .any (elig_any),
    .id  (elig_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_d     <= '0;
      pending   <= '0;
      state     <= ST_IDLE;
      cur_id    <= '0;
      interrupt <= 1'b0;
      out_bus   <= '0;
      ack_out   <= '0;
    end else begin
      irq_d   <= irq_in;
      // New edge beats a same-cycle acknowledge of the same bit.
      pending <= (pending & ~clr_v) | set_v;
      ack_out <= clr_v;

      if (read) out_bus <= (state == ST_REQ) ? mk_vec(cur_id) : 16'h0000;

      case (state)
        ST_IDLE: begin
          if (elig_any) begin
            cur_id    <= elig_id;
            interrupt <= 1'b1;
            state     <= ST_REQ;
          end
        end
        // cur_id stays frozen here so the vector matches what was raised.
        ST_REQ: begin
          if (read) begin
            interrupt <= 1'b0;
            state     <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (ack_cmd) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst, read, write;
  logic [15:0]  in_bus;
  logic [N-1:0] irq_in;
  logic [15:0]  out_bus;
  logic         interrupt;
  logic [N-1:0] ack_out;

  int n_tests = 0;
  int n_fail  = 0;
  bit use_model = 0;

  irq_controller #(.NUM_IRQ(N)) dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .in_bus(in_bus),
    .irq_in(irq_in), .out_bus(out_bus), .interrupt(interrupt), .ack_out(ack_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (transaction view) ----------------
  bit          m_pend [N];
  bit          m_prev [N];
  bit          m_mask [N];
  int          m_phase;     // 0 waiting for a source, 1 raised, 2 vector taken
  int          m_id;
  logic        e_int;
  logic [15:0] e_out;
  logic [N-1:0] e_ack;

  function automatic int pick();
    for (int i = 0; i < N; i++) if (m_pend[i] && m_mask[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    int p;
    bit nxt [N];
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_prev[i] = 0; m_mask[i] = 1; end
      m_phase = 0; m_id = 0; e_int = 0; e_out = 16'h0000; e_ack = '0;
      return;
    end
    p = pick();
    nxt = m_pend;
    e_ack = '0;
    if (read) e_out = (m_phase == 1) ? (16'h8000 + 16'(m_id)) : 16'h0000;
    if (m_phase == 0 && p >= 0) begin
      m_id = p; e_int = 1; m_phase = 1;
    end else if (m_phase == 1 && read) begin
      e_int = 0; m_phase = 2;
    end else if (m_phase == 2 && write && !read && !in_bus[15]) begin
      nxt[m_id] = 0; e_ack[m_id] = 1'b1; m_phase = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (irq_in[i] && !m_prev[i]) nxt[i] = 1;
      m_prev[i] = irq_in[i];
    end
`ifdef IRQ_MASK_EN
    if (write && !read && in_bus[15])
      for (int i = 0; i < N; i++) m_mask[i] = in_bus[i];
`endif
    m_pend = nxt;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    if (use_model) begin
      chk("model_int", 16'(interrupt), 16'(e_int));
      chk("model_out", out_bus, e_out);
      chk("model_ack", 16'(ack_out), 16'(e_ack));
    end
  endtask

  task automatic drive(input logic [N-1:0] irq, input logic rd, input logic wr, input logic [15:0] bus);
    irq_in = irq; read = rd; write = wr; in_bus = bus;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [N-1:0] irq;
    logic         rd;
    logic         wr;
    logic [15:0]  bus;
    logic         ei;
    logic [15:0]  eo;
    logic [N-1:0] ea;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst = 1'b1;
    drive('0, 0, 0, 16'h0000);
    // single source: edge, raise, read, ack
    tbl.push_back('{8'h08, 0, 0, 16'h0000, 0, 16'h0000, 8'h00});
    tbl.push_back('{8'h08, 0, 0, 16'h0000, 1, 16'h0000, 8'h00});
    tbl.push_back('{8'h08, 1, 0, 16'h0000, 0, 16'h8003, 8'h00});
    tbl.push_back('{8'h08, 0, 1, 16'h0000, 0, 16'h8003, 8'h08});
    tbl.push_back('{8'h00, 0, 0, 16'h0000, 0, 16'h8003, 8'h00});
    tbl.push_back('{8'h00, 0, 0, 16'h0000, 0, 16'h8003, 8'h00});
    // simultaneous 5 and 2: 2 first, then 5
    tbl.push_back('{8'h24, 0, 0, 16'h0000, 0, 16'h8003, 8'h00});
    tbl.push_back('{8'h24, 0, 0, 16'h0000, 1, 16'h8003, 8'h00});
    tbl.push_back('{8'h24, 1, 0, 16'h0000, 0, 16'h8002, 8'h00});
    tbl.push_back('{8'h24, 0, 1, 16'h0000, 0, 16'h8002, 8'h04});
    tbl.push_back('{8'h20, 0, 0, 16'h0000, 1, 16'h8002, 8'h00});
    tbl.push_back('{8'h20, 1, 0, 16'h0000, 0, 16'h8005, 8'h00});
    tbl.push_back('{8'h20, 0, 1, 16'h0000, 0, 16'h8005, 8'h20});
    tbl.push_back('{8'h00, 0, 0, 16'h0000, 0, 16'h8005, 8'h00});
    // ID 4 raised, higher-priority 1 arrives in REQ: 4 still delivered
    tbl.push_back('{8'h10, 0, 0, 16'h0000, 0, 16'h8005, 8'h00});
    tbl.push_back('{8'h10, 0, 0, 16'h0000, 1, 16'h8005, 8'h00});
    tbl.push_back('{8'h12, 0, 0, 16'h0000, 1, 16'h8005, 8'h00});
    tbl.push_back('{8'h12, 1, 0, 16'h0000, 0, 16'h8004, 8'h00});
    tbl.push_back('{8'h12, 0, 1, 16'h0000, 0, 16'h8004, 8'h10});
    tbl.push_back('{8'h02, 0, 0, 16'h0000, 1, 16'h8004, 8'h00});
    tbl.push_back('{8'h02, 1, 0, 16'h0000, 0, 16'h8001, 8'h00});
    tbl.push_back('{8'h02, 0, 1, 16'h0000, 0, 16'h8001, 8'h02});
    tbl.push_back('{8'h00, 0, 0, 16'h0000, 0, 16'h8001, 8'h00});
    // read / ack in IDLE, ack in REQ, read+write together
    tbl.push_back('{8'h00, 1, 0, 16'h0000, 0, 16'h0000, 8'h00});
    tbl.push_back('{8'h00, 0, 1, 16'h0000, 0, 16'h0000, 8'h00});
    tbl.push_back('{8'h08, 0, 0, 16'h0000, 0, 16'h0000, 8'h00});
    tbl.push_back('{8'h08, 0, 1, 16'h0000, 1, 16'h0000, 8'h00});
    tbl.push_back('{8'h08, 0, 1, 16'h0000, 1, 16'h0000, 8'h00});
    tbl.push_back('{8'h08, 1, 1, 16'h0000, 0, 16'h8003, 8'h00});
    tbl.push_back('{8'h08, 0, 1, 16'h0000, 0, 16'h8003, 8'h08});
    tbl.push_back('{8'h00, 0, 0, 16'h0000, 0, 16'h8003, 8'h00});

    cyc(); cyc();
    chk("rst_int", 16'(interrupt), 16'h0);
    chk("rst_out", out_bus, 16'h0000);
    chk("rst_ack", 16'(ack_out), 16'h0);
    rst = 1'b0;

    foreach (tbl[k]) begin
      drive(tbl[k].irq, tbl[k].rd, tbl[k].wr, tbl[k].bus);
      cyc();
      chk($sformatf("row%0d_int", k), 16'(interrupt), 16'(tbl[k].ei));
      chk($sformatf("row%0d_out", k), out_bus, tbl[k].eo);
      chk($sformatf("row%0d_ack", k), 16'(ack_out), 16'(tbl[k].ea));
    end

    // mask: bit 0 disabled, then re-enabled
    drive(8'h00, 0, 1, 16'h80FE); cyc();
    drive(8'h01, 0, 0, 16'h0000); cyc(); cyc(); cyc();
`ifdef IRQ_MASK_EN
    chk("mask_hold_int", 16'(interrupt), 16'h0);
`else
    chk("mask_hold_int", 16'(interrupt), 16'h1);
`endif
    drive(8'h01, 0, 1, 16'h80FF); cyc();
    drive(8'h01, 0, 0, 16'h0000); cyc();
    chk("mask_open_int", 16'(interrupt), 16'h1);
    drive(8'h01, 1, 0, 16'h0000); cyc();
    chk("mask_vec", out_bus, 16'h8000);
    drive(8'h01, 0, 1, 16'h0000); cyc();
    chk("mask_ack", 16'(ack_out), 16'h0001);
    drive(8'h00, 0, 0, 16'h0000); cyc();

    // reset while in SERVICE, with an ack write in the reset cycle
    drive(8'h08, 0, 0, 16'h0000); cyc(); cyc();
    drive(8'h08, 1, 0, 16'h0000); cyc();
    chk("rsvc_vec", out_bus, 16'h8003);
    rst = 1'b1; drive(8'h08, 0, 1, 16'h0000); cyc();
    chk("rsvc_int", 16'(interrupt), 16'h0);
    chk("rsvc_out", out_bus, 16'h0000);
    chk("rsvc_ack", 16'(ack_out), 16'h0);
    rst = 1'b0; drive(8'h00, 0, 0, 16'h0000); cyc(); cyc();
    chk("rsvc_quiet", 16'(interrupt), 16'h0);
    chk("rsvc_noack", 16'(ack_out), 16'h0);
    drive(8'h08, 0, 0, 16'h0000); cyc(); cyc();
    chk("rsvc_reedge", 16'(interrupt), 16'h1);
    drive(8'h08, 1, 0, 16'h0000); cyc();
    chk("rsvc_vec2", out_bus, 16'h8003);
    drive(8'h08, 0, 1, 16'h0000); cyc();
    chk("rsvc_ack2", 16'(ack_out), 16'h0008);
    drive(8'h00, 0, 0, 16'h0000); cyc();

    // random traffic against the model
    rst = 1'b1; cyc(); rst = 1'b0;
    use_model = 1;
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] nirq;
      nirq = irq_in;
      for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) nirq[b] = ~nirq[b];
      irq_in = nirq;
      read   = ($urandom_range(0, 3) == 0);
      write  = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 9))
        0:       in_bus = 16'h8000 | 16'($urandom_range(0, 255));
        1:       in_bus = 16'h80FF;
        2:       in_bus = 16'($urandom_range(0, 32767));
        default: in_bus = 16'h0000;
      endcase
      cyc();
    end
    use_model = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
